// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller: stack pointer, 16/32-bit accesses over a 16-bit req/ack port
module mem_stage_ctrl #(
    parameter int WbSize   = 2,
    parameter int MemSize  = 9,
    parameter int flagSize = 4,
    parameter int AddrSize = 20,
    parameter logic [AddrSize-1:0] SpInit = 20'hFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MemSize-1:0]  i_Mem,
    input  logic [WbSize-1:0]   i_WB,
    input  logic [31:0]         i_pc,
    input  logic [2:0]          i_Rdst,
    input  logic [15:0]         i_alu,
    input  logic [15:0]         i_read_data1,
    input  logic [flagSize-1:0] i_flag,
    input  logic                i_mem_ack,
    input  logic [15:0]         i_mem_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [AddrSize-1:0] o_mem_addr,
    output logic [15:0]         o_mem_wdata,
    output logic                o_stall,
    output logic [WbSize-1:0]   o_WB,
    output logic [2:0]          o_Rdst,
    output logic [15:0]         o_alu,
    output logic [flagSize-1:0] o_flag,
    output logic [31:0]         o_mem_data,
    output logic [AddrSize-1:0] o_sp
);

    typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2} state_t;

    state_t                r_state, w_next;
    logic [AddrSize-1:0]   r_sp;
    logic [WbSize-1:0]     r_wb;
    logic [2:0]            r_rdst;
    logic [15:0]           r_alu;
    logic [flagSize-1:0]   r_flag;
    logic                  r_wide, r_we, r_stack;
    logic [15:0]           r_pc_lo;
    logic                  r_req, r_mem_we;
    logic [AddrSize-1:0]   r_addr;
    logic [15:0]           r_wdata;

    logic                  w_rd, w_wr, w_stack, w_wide, w_pcsrc, w_op;
    logic                  w_final, w_done;
    logic [AddrSize-1:0]   w_one, w_step, w_first_addr, w_second_addr;
    logic [15:0]           w_first_wdata;
    logic                  w_unused;

    assign w_rd     = i_Mem[0];
    assign w_wr     = i_Mem[1];
    assign w_stack  = i_Mem[2];
    assign w_wide   = i_Mem[3];
    assign w_pcsrc  = i_Mem[4];
    assign w_op     = w_rd | w_wr;
    assign w_unused = ^i_Mem[MemSize-1:5];

    assign w_one  = {{(AddrSize-1){1'b0}}, 1'b1};
    assign w_step = {{(AddrSize-2){1'b0}}, r_wide, ~r_wide};

    // Push starts at SP and walks down; pop starts at SP+1 and walks up.
    assign w_first_addr  = w_stack ? (w_wr ? r_sp : r_sp + w_one)
                                   : {{(AddrSize-16){1'b0}}, i_alu};
    assign w_second_addr = (r_stack & r_we) ? r_addr - w_one : r_addr + w_one;
    assign w_first_wdata = w_wide ? i_pc[31:16] : (w_pcsrc ? i_pc[15:0] : i_read_data1);

    always_comb begin
        w_next  = r_state;
        w_final = 1'b0;
        case (r_state)
            S_IDLE: if (w_op) w_next = S_ACC1;
            S_ACC1: begin
                w_final = ~r_wide;
                if (i_mem_ack) w_next = r_wide ? S_ACC2 : S_IDLE;
            end
            S_ACC2: begin
                w_final = 1'b1;
                if (i_mem_ack) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        w_done  = i_mem_ack & w_final;
        o_stall = ((r_state == S_IDLE) & w_op) | ((r_state != S_IDLE) & ~w_done);
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sp       <= SpInit;
            r_wb       <= '0;
            r_rdst     <= '0;
            r_alu      <= '0;
            r_flag     <= '0;
            r_wide     <= 1'b0;
            r_we       <= 1'b0;
            r_stack    <= 1'b0;
            r_pc_lo    <= '0;
            r_req      <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            o_WB       <= '0;
            o_Rdst     <= '0;
            o_alu      <= '0;
            o_flag     <= '0;
            o_mem_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        r_wb     <= i_WB;
                        r_rdst   <= i_Rdst;
                        r_alu    <= i_alu;
                        r_flag   <= i_flag;
                        r_wide   <= w_wide;
                        r_we     <= w_wr;
                        r_stack  <= w_stack;
                        r_pc_lo  <= i_pc[15:0];
                        r_req    <= 1'b1;
                        r_mem_we <= w_wr;
                        r_addr   <= w_first_addr;
                        r_wdata  <= w_first_wdata;
                        o_WB     <= '0;
                    end else begin
                        o_WB       <= i_WB;
                        o_Rdst     <= i_Rdst;
                        o_alu      <= i_alu;
                        o_flag     <= i_flag;
                        o_mem_data <= '0;
                    end
                end
                S_ACC1: begin
                    if (i_mem_ack) begin
                        o_mem_data <= r_we ? 32'h0 : {16'h0, i_mem_rdata};
                        if (r_wide) begin
                            r_addr  <= w_second_addr;
                            r_wdata <= r_pc_lo;
                        end
                    end
                end
                S_ACC2: begin
                    if (i_mem_ack) o_mem_data[31:16] <= r_we ? 16'h0 : i_mem_rdata;
                end
                default: ;
            endcase

            // Final ack: retire the op for exactly one cycle and settle SP.
            if (w_done) begin
                r_req  <= 1'b0;
                o_WB   <= r_wb;
                o_Rdst <= r_rdst;
                o_alu  <= r_alu;
                o_flag <= r_flag;
                if (r_stack) r_sp <= r_we ? r_sp - w_step : r_sp + w_step;
            end
        end
    end

    assign o_mem_req   = r_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_sp        = r_sp;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller consuming the ALU/MEM pipeline buffer outputs.
- Decodes the memory control word, owns the stack pointer, and runs 16-bit single-word and 32-bit two-word accesses (PC push/pop) over a 16-bit req/ack data memory port.
- Stalls the upstream buffer while busy, then drives the MEM/WB-side registers.

Parameters:
WbSize, 2, write-back control width (passed through)
MemSize, 9, memory control word width
flagSize, 4, flag width (passed through)
AddrSize, 20, data memory address width
SpInit, 20'hFFFFF, stack pointer reset value

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets)
i_Mem  input  MemSize  control: [0] rd, [1] wr, [2] stack, [3] wide, [4] pc_src, [MemSize-1:5] ignored
i_WB  input  WbSize  write-back control
i_pc  input  32  PC for push
i_Rdst  input  3  destination register
i_alu  input  16  ALU result / effective address
i_read_data1  input  16  store data
i_flag  input  flagSize  flags
i_mem_ack  input  1  memory done; read data valid this cycle
i_mem_rdata  input  16  memory read data
o_mem_req  output  1  access request
o_mem_we  output  1  1=write
o_mem_addr  output  AddrSize  address
o_mem_wdata  output  16  write data
o_stall  output  1  upstream buffer enable = ~o_stall
o_WB  output  WbSize  registered, 0 = bubble
o_Rdst  output  3  registered
o_alu  output  16  registered
o_flag  output  flagSize  registered
o_mem_data  output  32  read result: [15:0] first word, [31:16] second word (wide only)
o_sp  output  AddrSize  current stack pointer

Behaviour:
- Reset (rst==0 at edge): state IDLE, SP=SpInit, all outputs 0. Applies mid-access: request dropped, SP not updated, captured op discarded.
- States: IDLE, ACC1, ACC2.
- IDLE, op without rd/wr: o_WB, o_Rdst, o_alu, o_flag registered next edge; o_mem_data=0; 1-cycle latency; o_stall=0.
- IDLE, rd or wr set:
  - o_stall=1 combinationally.
  - At the edge, all inputs are captured, state goes to ACC1, and the first access is issued from registers.
  - o_WB is 0 while busy.
- Access stream: o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata are held stable until an i_mem_ack edge. An ack is ignored when the state is IDLE.
- Addressing:
  - Non-stack: addr = zero-extended i_alu; wide second word at addr+1.
  - Push (stack&wr): first at SP, second at SP-1; SP -= (wide?2:1).
  - Pop (stack&rd): first at SP+1, second at SP+2; SP += (wide?2:1).
  - SP arithmetic wraps modulo 2^AddrSize.
- Write data:
  - Wide: first word pc[31:16], second word pc[15:0], so a wide pop returns low word first.
  - Narrow: pc_src ? pc[15:0] : read_data1.
- Reads: first word latched to o_mem_data[15:0] on the ACC1 ack, second word to [31:16] on the ACC2 ack. Narrow reads zero [31:16].
- Transitions:
  - ACC1 & ack & wide → ACC2.
  - ACC1 & ack & !wide → IDLE.
  - ACC2 & ack → IDLE.
  - No ack: stay in the current state.
- Completion edge (final ack): SP updated; captured WB/Rdst/alu/flag loaded to outputs for exactly one cycle; o_mem_req deasserted.
- o_stall = (IDLE & (rd|wr)) | (busy & ~(i_mem_ack & final access)). It drops in the final-ack cycle so upstream advances exactly once and no op is re-executed.
- rd and wr both set: treated as write.

Test Plan:
- Reset with rst=0 for 2 cycles → SP=20'hFFFFF, o_mem_req=0, all outputs 0; ALU-only op (i_Mem=0, i_WB=2'b01, i_alu=16'h1234) → o_alu=16'h1234, o_WB=01 next edge, o_stall=0 throughout.
- Narrow load, i_alu=16'h0040, ack after 3 wait cycles with rdata=16'hBEEF → addr 20'h00040 held 4 cycles, o_mem_data=32'h0000BEEF, o_WB valid one cycle, o_stall high until ack cycle.
- Wide push pc=32'hAABB_CCDD from SP=20'hFFFFF, immediate acks → writes AABB@FFFFF then CCDD@FFFFE, SP=20'hFFFFD, o_stall high 2 cycles.
- Wide pop immediately after the push, returning CCDD then AABB → reads at FFFFE then FFFFF, o_mem_data=32'hAABB_CCDD, SP=20'hFFFFF.
- Narrow pop at SP=20'hFFFFF → address wraps to 20'h00000, SP=20'h00000.
- rst=0 asserted in ACC2 of a wide push → next cycle IDLE, SP=SpInit, o_mem_req=0, o_WB=0; a stray ack afterwards causes no state change.
